// File: rtl/cache_pkg.sv
// Shared cache definitions: refill FSM state encoding and geometry-derived widths.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITEBACK  = 3'd1,
    ST_FETCH_REQ  = 3'd2,
    ST_FETCH_WAIT = 3'd3,
    ST_FILL       = 3'd4
  } refill_state_t;

  function automatic int offset_w(input int block_size);
    return $clog2(block_size);
  endfunction

  function automatic int index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int address_width, input int num_sets, input int block_size);
    return address_width - $clog2(num_sets) - $clog2(block_size);
  endfunction

  function automatic int block_bits(input int block_size);
    return block_size * 8;
  endfunction

endpackage

// File: rtl/victim_select.sv
// Victim way picker: lowest-index invalid way, or the round-robin way when the set is full.
module victim_select #(
  parameter int NUM_WAYS = 4,
  localparam int PTR_W = $clog2(NUM_WAYS)
)(
  input  logic [NUM_WAYS-1:0] way_valid,
  input  logic [PTR_W-1:0]    rr_ptr,
  output logic [NUM_WAYS-1:0] victim
);

  logic [NUM_WAYS-1:0] first_free;
  logic                all_valid;

  // Scanning downwards leaves the lowest free way as the survivor.
  always_comb begin
    first_free = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!way_valid[i]) begin
        first_free    = '0;
        first_free[i] = 1'b1;
      end
    end
  end

  assign all_valid = &way_valid;

  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
    assign victim[gi] = all_valid ? (rr_ptr == PTR_W'(gi)) : first_free[gi];
  end

endmodule

// File: rtl/way_refill_ctrl.sv
// Cache miss refill sequencer: victim choice, optional dirty writeback, block fetch and way fill.
// Writeback support is compiled in only when WAY_REFILL_WB_EN is defined (write-through otherwise).
module way_refill_ctrl
  import cache_pkg::*;
#(
  parameter int NUM_WAYS      = 4,
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_SIZE    = 32,
  parameter int NUM_SETS      = 64,
  localparam int OFFSET_W   = offset_w(BLOCK_SIZE),
  localparam int INDEX_W    = index_w(NUM_SETS),
  localparam int TAG_W      = tag_w(ADDRESS_WIDTH, NUM_SETS, BLOCK_SIZE),
  localparam int BLOCK_BITS = block_bits(BLOCK_SIZE)
)(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      miss_valid,
  output logic                      miss_ready,
  input  logic [TAG_W-1:0]          miss_tag,
  input  logic [INDEX_W-1:0]        miss_index,
  input  logic [NUM_WAYS-1:0]       way_valid,
  input  logic [NUM_WAYS-1:0]       way_dirty,
  input  logic [NUM_WAYS*TAG_W-1:0] way_tags,
  input  logic [BLOCK_BITS-1:0]     wb_data,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_write,
  output logic [ADDRESS_WIDTH-1:0]  mem_req_addr,
  output logic [BLOCK_BITS-1:0]     mem_req_wdata,
  input  logic                      mem_rsp_valid,
  input  logic [BLOCK_BITS-1:0]     mem_rsp_data,
  output logic                      fill_en,
  output logic [NUM_WAYS-1:0]       fill_way,
  output logic [INDEX_W-1:0]        fill_index,
  output logic [TAG_W-1:0]          fill_tag,
  output logic [BLOCK_BITS-1:0]     fill_data,
  output logic                      busy,
  output logic                      done
);

  localparam int PTR_W = $clog2(NUM_WAYS);

  refill_state_t         state_reg, state_next;
  logic [TAG_W-1:0]      tag_reg;
  logic [INDEX_W-1:0]    index_reg;
  logic [NUM_WAYS-1:0]   victim_reg;
  logic                  used_rr_reg;
  logic [BLOCK_BITS-1:0] data_reg;
  logic [PTR_W-1:0]      rr_ptr_reg;
  logic [NUM_WAYS-1:0]   victim;
  logic                  accept;
  logic                  wb_needed;

  victim_select #(.NUM_WAYS(NUM_WAYS)) u_victim_select (
    .way_valid (way_valid),
    .rr_ptr    (rr_ptr_reg),
    .victim    (victim)
  );

  assign miss_ready = (state_reg == ST_IDLE);
  assign accept     = miss_valid && miss_ready;

`ifdef WAY_REFILL_WB_EN
  logic [TAG_W-1:0] victim_tag_reg;
  logic [TAG_W-1:0] victim_tag;

  always_comb begin
    victim_tag = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (victim[i]) victim_tag = way_tags[i*TAG_W +: TAG_W];
    end
  end

  assign wb_needed = |(victim & way_valid & way_dirty);

  always_ff @(posedge clk) begin
    if (reset) victim_tag_reg <= '0;
    else if (accept) victim_tag_reg <= victim_tag;
  end
`else
  logic unused_wb_inputs;
  assign unused_wb_inputs = ^{way_dirty, way_tags, wb_data};
  assign wb_needed        = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:       if (miss_valid) state_next = wb_needed ? ST_WRITEBACK : ST_FETCH_REQ;
`ifdef WAY_REFILL_WB_EN
      ST_WRITEBACK:  if (mem_req_ready) state_next = ST_FETCH_REQ;
`endif
      ST_FETCH_REQ:  if (mem_req_ready) state_next = ST_FETCH_WAIT;
      ST_FETCH_WAIT: if (mem_rsp_valid) state_next = ST_FILL;
      ST_FILL:       state_next = ST_IDLE;
      default:       state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      tag_reg     <= '0;
      index_reg   <= '0;
      victim_reg  <= '0;
      used_rr_reg <= 1'b0;
      data_reg    <= '0;
      rr_ptr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        tag_reg     <= miss_tag;
        index_reg   <= miss_index;
        victim_reg  <= victim;
        used_rr_reg <= &way_valid;
      end
      if (state_reg == ST_FETCH_WAIT && mem_rsp_valid) data_reg <= mem_rsp_data;
      // Only refills that evicted by round-robin move the pointer on.
      if (state_reg == ST_FILL && used_rr_reg) rr_ptr_reg <= rr_ptr_reg + PTR_W'(1);
    end
  end

  always_comb begin
    mem_req_valid = (state_reg == ST_FETCH_REQ);
    mem_req_write = 1'b0;
    mem_req_wdata = '0;
    mem_req_addr  = '0;
    if (state_reg == ST_FETCH_REQ) mem_req_addr = {tag_reg, index_reg, {OFFSET_W{1'b0}}};
`ifdef WAY_REFILL_WB_EN
    if (state_reg == ST_WRITEBACK) begin
      mem_req_valid = 1'b1;
      mem_req_write = 1'b1;
      mem_req_wdata = wb_data;
      mem_req_addr  = {victim_tag_reg, index_reg, {OFFSET_W{1'b0}}};
    end
`endif
  end

  assign fill_en    = (state_reg == ST_FILL);
  assign done       = fill_en;
  assign busy       = (state_reg != ST_IDLE);
  assign fill_way   = fill_en ? victim_reg : '0;
  assign fill_index = fill_en ? index_reg : '0;
  assign fill_tag   = fill_en ? tag_reg : '0;
  assign fill_data  = fill_en ? data_reg : '0;

endmodule

// File: tb/tb_way_refill_ctrl.sv
// Randomized refill transactions checked cycle by cycle against a transaction-level model.
module tb_way_refill_ctrl;

  localparam int NUM_WAYS   = 4;
  localparam int TAG_W      = 21;
  localparam int INDEX_W    = 6;
  localparam int BLOCK_BITS = 256;
`ifdef WAY_REFILL_WB_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic                      clk;
  logic                      reset;
  logic                      miss_valid;
  logic                      miss_ready;
  logic [TAG_W-1:0]          miss_tag;
  logic [INDEX_W-1:0]        miss_index;
  logic [NUM_WAYS-1:0]       way_valid;
  logic [NUM_WAYS-1:0]       way_dirty;
  logic [NUM_WAYS*TAG_W-1:0] way_tags;
  logic [BLOCK_BITS-1:0]     wb_data;
  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic                      mem_req_write;
  logic [31:0]               mem_req_addr;
  logic [BLOCK_BITS-1:0]     mem_req_wdata;
  logic                      mem_rsp_valid;
  logic [BLOCK_BITS-1:0]     mem_rsp_data;
  logic                      fill_en;
  logic [NUM_WAYS-1:0]       fill_way;
  logic [INDEX_W-1:0]        fill_index;
  logic [TAG_W-1:0]          fill_tag;
  logic [BLOCK_BITS-1:0]     fill_data;
  logic                      busy;
  logic                      done;

  way_refill_ctrl dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_tag(miss_tag), .miss_index(miss_index),
    .way_valid(way_valid), .way_dirty(way_dirty), .way_tags(way_tags), .wb_data(wb_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .fill_en(fill_en), .fill_way(fill_way), .fill_index(fill_index), .fill_tag(fill_tag),
    .fill_data(fill_data), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int rr_model;
  bit chk_en;

  // Expected outputs for the current cycle.
  bit                    e_miss_ready, e_busy, e_req, e_write, e_fill, e_done, e_zero;
  logic [31:0]           e_addr;
  logic [BLOCK_BITS-1:0] e_wdata, e_data;
  logic [NUM_WAYS-1:0]   e_way, e_way_lit;
  logic [INDEX_W-1:0]    e_index;
  logic [TAG_W-1:0]      e_tag;

  task automatic cmp(input string name, input logic [BLOCK_BITS-1:0] act, input logic [BLOCK_BITS-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("miss_ready", miss_ready, e_miss_ready);
      cmp("busy", busy, e_busy);
      cmp("done", done, e_done);
      cmp("fill_en", fill_en, e_fill);
      cmp("mem_req_valid", mem_req_valid, e_req);
      if (e_req) begin
        cmp("mem_req_write", mem_req_write, e_write);
        cmp("mem_req_addr", mem_req_addr, e_addr);
        if (e_write) cmp("mem_req_wdata", mem_req_wdata, e_wdata);
      end
      if (e_fill) begin
        cmp("fill_way", fill_way, e_way);
        cmp("fill_index", fill_index, e_index);
        cmp("fill_tag", fill_tag, e_tag);
        cmp("fill_data", fill_data, e_data);
        if (e_way_lit != 4'b0) cmp("fill_way_literal", fill_way, e_way_lit);
      end
      if (e_zero) begin
        cmp("rst_mem_req_write", mem_req_write, 1'b0);
        cmp("rst_mem_req_addr", mem_req_addr, 32'h0);
        cmp("rst_mem_req_wdata", mem_req_wdata, '0);
        cmp("rst_fill_way", fill_way, 4'h0);
        cmp("rst_fill_index", fill_index, 6'h0);
        cmp("rst_fill_tag", fill_tag, 21'h0);
        cmp("rst_fill_data", fill_data, '0);
      end
      if (!WB_EN) begin
        cmp("wt_mem_req_write", mem_req_write, 1'b0);
        cmp("wt_mem_req_wdata", mem_req_wdata, '0);
      end
    end
  end

  function automatic logic [BLOCK_BITS-1:0] rand_block();
    logic [BLOCK_BITS-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [NUM_WAYS*TAG_W-1:0] rand_tags();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[NUM_WAYS*TAG_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input bit mr, input bit bsy, input bit req, input bit fe);
    e_miss_ready = mr;
    e_busy       = bsy;
    e_req        = req;
    e_write      = 1'b0;
    e_fill       = fe;
    e_done       = fe;
    e_zero       = 1'b0;
    e_way_lit    = 4'b0;
  endtask

  // Lookup-side inputs only matter in the acceptance cycle; churn them elsewhere.
  task automatic scramble(input bit hold);
    miss_valid    = hold;
    miss_tag      = TAG_W'($urandom);
    miss_index    = INDEX_W'($urandom);
    way_valid     = 4'($urandom);
    way_dirty     = 4'($urandom);
    way_tags      = rand_tags();
    mem_rsp_valid = 1'($urandom);
    mem_rsp_data  = rand_block();
  endtask

  task automatic idle_cycle();
    scramble(1'b0);
    mem_req_ready = 1'($urandom);
    wb_data       = rand_block();
    expect_state(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic run_miss(input logic [TAG_W-1:0] tag, input logic [INDEX_W-1:0] idx,
                          input logic [3:0] vld, input logic [3:0] dty,
                          input logic [NUM_WAYS*TAG_W-1:0] tags,
                          input int d_wb, input int d_rd, input int d_rsp,
                          input bit hold, input bit abort, input logic [3:0] way_lit);
    int v;
    bit use_rr, wb, hold_busy;
    logic [TAG_W-1:0] vtag;
    logic [BLOCK_BITS-1:0] wbd, rdata;
    use_rr = (vld == 4'hF);
    v = rr_model;
    if (!use_rr) for (int i = 3; i >= 0; i--) if (!vld[i]) v = i;
    wb        = WB_EN && vld[v] && dty[v];
    vtag      = tags[v*TAG_W +: TAG_W];
    wbd       = rand_block();
    rdata     = rand_block();
    hold_busy = hold && !abort;

    miss_valid = 1'b1; miss_tag = tag; miss_index = idx;
    way_valid = vld; way_dirty = dty; way_tags = tags; wb_data = wbd;
    mem_req_ready = 1'($urandom); mem_rsp_valid = 1'($urandom); mem_rsp_data = rand_block();
    expect_state(1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    if (wb) begin
      for (int i = 0; i <= d_wb; i++) begin
        scramble(hold_busy);
        mem_req_ready = (i == d_wb);
        expect_state(1'b0, 1'b1, 1'b1, 1'b0);
        e_write = 1'b1;
        e_addr  = {vtag, idx, 5'd0};
        e_wdata = wbd;
        tick();
      end
    end

    for (int i = 0; i <= d_rd; i++) begin
      scramble(hold_busy);
      wb_data = rand_block();
      mem_req_ready = (i == d_rd);
      expect_state(1'b0, 1'b1, 1'b1, 1'b0);
      e_addr = {tag, idx, 5'd0};
      tick();
    end

    for (int i = 0; i <= d_rsp; i++) begin
      scramble(hold_busy);
      mem_req_ready = 1'($urandom);
      mem_rsp_valid = 1'b0;
      if (i == d_rsp) begin
        if (abort) reset = 1'b1;
        else begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = rdata;
        end
      end
      expect_state(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end

    if (abort) begin
      // Abandoned refill: back in IDLE with everything cleared, late response ignored.
      reset = 1'b0; rr_model = 0; miss_valid = 1'b0;
      mem_rsp_valid = 1'b1; mem_rsp_data = rdata;
      expect_state(1'b1, 1'b0, 1'b0, 1'b0);
      e_zero = 1'b1;
      tick();
      expect_state(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      mem_rsp_valid = 1'b0;
      return;
    end

    scramble(hold_busy);
    mem_req_ready = 1'($urandom);
    expect_state(1'b0, 1'b1, 1'b0, 1'b1);
    e_way = 4'b1 << v; e_index = idx; e_tag = tag; e_data = rdata; e_way_lit = way_lit;
    tick();
    if (use_rr) rr_model = (rr_model + 1) % NUM_WAYS;
    miss_valid = hold_busy;
  endtask

  initial begin
    logic [NUM_WAYS*TAG_W-1:0] t;
    vectors = 0; miscompares = 0; rr_model = 0; chk_en = 1'b0;
    reset = 1'b1; miss_valid = 1'b0; miss_tag = '0; miss_index = '0;
    way_valid = '0; way_dirty = '0; way_tags = '0; wb_data = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    expect_state(1'b1, 1'b0, 1'b0, 1'b0);
    e_zero = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    idle_cycle();
    idle_cycle();

    // First free way is way 2; pointer must not move.
    run_miss(21'h00aaa, 6'd1, 4'b1011, 4'b1111, rand_tags(), 0, 0, 0, 1'b0, 1'b0, 4'b0100);
    idle_cycle();
    run_miss(21'h00bbb, 6'd2, 4'b1111, 4'b0000, rand_tags(), 0, 0, 0, 1'b0, 1'b0, 4'b0001);
    run_miss(21'h00ccc, 6'd3, 4'b1111, 4'b0000, rand_tags(), 0, 1, 1, 1'b0, 1'b0, 4'b0010);
    run_miss(21'h00ddd, 6'd4, 4'b1111, 4'b0000, rand_tags(), 0, 0, 2, 1'b0, 1'b0, 4'b0100);
    // Pointer at 3, clean full set: evict way 3, then wrap to 0.
    run_miss(21'h00eee, 6'd9, 4'b1111, 4'b0000, rand_tags(), 0, 0, 0, 1'b0, 1'b0, 4'b1000);
    run_miss(21'h00fff, 6'd7, 4'b1111, 4'b0000, rand_tags(), 0, 0, 0, 1'b0, 1'b0, 4'b0001);
    // Dirty victim way 1 with tag 0x12345 at index 5.
    t = rand_tags();
    t[1*TAG_W +: TAG_W] = 21'h12345;
    run_miss(21'h0abcd, 6'd5, 4'b1111, 4'b0010, t, 1, 0, 0, 1'b0, 1'b0, 4'b0010);
    idle_cycle();
    // Slow memory: ready low for 4 cycles.
    run_miss(21'h1f00f, 6'd33, 4'b0111, 4'b0000, rand_tags(), 4, 4, 3, 1'b0, 1'b0, 4'b1000);
    // Back-to-back misses with miss_valid held through busy.
    run_miss(21'h0aaaa, 6'd10, 4'b1110, 4'b0000, rand_tags(), 0, 1, 1, 1'b1, 1'b0, 4'b0001);
    run_miss(21'h05555, 6'd11, 4'b1101, 4'b0000, rand_tags(), 0, 0, 1, 1'b0, 1'b0, 4'b0010);
    // Reset during FETCH_WAIT, then pointer must be back at way 0.
    run_miss(21'h13579, 6'd12, 4'b0011, 4'b0000, rand_tags(), 0, 0, 2, 1'b0, 1'b1, 4'b0);
    run_miss(21'h02468, 6'd13, 4'b1111, 4'b0000, rand_tags(), 0, 0, 0, 1'b0, 1'b0, 4'b0001);

    for (int n = 0; n < 80; n++) begin
      logic [3:0] vld;
      bit hold, abort;
      vld   = ($urandom % 2 == 0) ? 4'hF : 4'($urandom);
      abort = ($urandom % 16 == 0);
      hold  = !abort && ($urandom % 4 == 0);
      run_miss(TAG_W'($urandom), INDEX_W'($urandom), vld, 4'($urandom), rand_tags(),
               int'($urandom % 3), int'($urandom % 4), int'($urandom % 4), hold, abort, 4'b0);
      if (!hold) repeat ($urandom % 3) idle_cycle();
    end
    idle_cycle();
    idle_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
